memory_system: RTL and testbench
================================

MEMORY_SYSTEM -- requirements
Module: memory_system

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 8, setting the width of every data register, bus and memory word.
REQ-002 The block SHALL have these ports (name direction width meaning):
- clk input 1: single clock, all state updates on rising edge.
- rst input 1: reset, asynchronous, active-high.
- ir_sclr input 1: synchronous clear of IR.
- mar_sclr input 1: synchronous clear of MAR.
- enaf input 1: flag register load enable.
- selop input 3: ALU operation select.
- shamt input 2: shifter mode.
- bank_wr_en input 1: register-bank write enable.
- busB_addr input 3: bank register driven on busB.
- busC_addr input 3: bank register written from busC.
- ir_en input 1: IR load enable.
- mar_en input 1: MAR load enable.
- wr_rdn input 1: memory direction, 1 = write, 0 = read.
- mdr_alu_n input 1: busC source, 1 = MDR, 0 = shifter output.
- mdr_en input 1: MDR load enable.
- busC_m, bus_alu_m, PC_m, DPTR_m, A_m, TEMP_m, ACC_m output 8 each: monitors of busC, shifter output, and bank registers PC, DPTR, A, TEMP, ACC.
- instruction output 5: IR[7:3].
- C, N, P, Z output 1 each: registered carry, negative, parity, zero flags.

Function
REQ-003 The register bank SHALL hold 8 registers addressed as 000 PC, 001 DPTR, 010 A, 011 TEMP, 100 R4, 101 R5, 110 R6, 111 ACC.
REQ-004 busB SHALL be the combinational read of bank[busB_addr].
REQ-005 The ALU SHALL take operand X = ACC and Y = busB, with selop: 000 Y, 001 X+Y, 010 X-Y, 011 X AND Y, 100 X OR Y, 101 X XOR Y, 110 Y+1, 111 Y-1; results are 8-bit and wrap modulo 256.
REQ-006 ALU carry SHALL be: carry-out for 001 and 110, borrow (X<Y) for 010, borrow (Y=0) for 111, and 0 otherwise.
REQ-007 The shifter SHALL process the ALU result with shamt: 00 pass, 01 logical left 1, 10 logical right 1, 11 rotate right 1; its output SHALL be bus_alu_m.
REQ-008 busC SHALL equal MDR when mdr_alu_n=1 and the shifter output otherwise; busC_m SHALL show busC.
REQ-009 When bank_wr_en=1, bank[busC_addr] SHALL load busC on the clock edge.
REQ-010 When enaf=1, on the clock edge:
- C SHALL load the ALU carry.
- Z SHALL load 1 iff the shifter output is 0.
- N SHALL load the shifter output's bit 7.
- P SHALL load 1 iff the shifter output has an even number of ones.
REQ-011 When enaf=0, the flags SHALL hold.
REQ-012 MAR (8 bits) SHALL clear on mar_sclr=1 and otherwise load busB when mar_en=1; mar_sclr SHALL take priority.
REQ-013 Memory SHALL be 256 x 8, indexed by MAR, and SHALL NOT be cleared by rst; its contents SHALL be zero at power-up.
REQ-014 MDR SHALL be updated as follows:
- mdr_en=1, wr_rdn=0: MDR loads mem[MAR].
- mdr_en=1, wr_rdn=1: MDR loads the shifter output.
- mdr_en=0, wr_rdn=1: mem[MAR] loads MDR.
- mdr_en=0, wr_rdn=0: no memory or MDR change.
REQ-015 IR (8 bits) SHALL clear on ir_sclr=1 and otherwise load MDR when ir_en=1; ir_sclr SHALL take priority.
REQ-016 All loads SHALL have 1-cycle latency: the new value is visible after the loading edge, and reads within the cycle see pre-edge values.
REQ-017 Simultaneous enables (for example, bank write, MAR load and MDR load in one cycle) SHALL all take effect, each using pre-edge operands.

Reset
REQ-018 Asserting rst SHALL immediately set all bank registers, MAR, MDR, IR and flags C, N, P, Z to 0 regardless of clk.
REQ-019 While rst is asserted, all other inputs SHALL be ignored.
REQ-020 After rst deasserts, normal operation SHALL resume on the next rising edge.
REQ-021 A reset mid-operation SHALL abort any pending load.

Verification
REQ-022 Reset: pulse rst for 20 ns -> PC_m, ACC_m, A_m, DPTR_m, TEMP_m, instruction, and C, N, P, Z are all 0.
REQ-023 Fetch/increment: after reset, apply mar_en=1, busB_addr=000 for one cycle, then selop=110, bank_wr_en=1, busC_addr=000, mdr_en=1, wr_rdn=0 for one cycle -> MAR=0, PC_m=1, MDR=mem[0].
REQ-024 MOV ACC,const: store 0x5A at mem[0] (via MDR load then write), then perform the fetch of REQ-023, then mdr_alu_n=1, bank_wr_en=1, busC_addr=111 -> ACC_m=0x5A, busC_m=0x5A.
REQ-025 Arithmetic/flags: with ACC=0xFF and A=0x01, apply selop=001, busB_addr=010, enaf=1, busC_addr=111 -> ACC_m=0x00, C=1, Z=1, N=0, P=1.
REQ-026 Shifter: with ACC=0x81 and busB=ACC, apply selop=000: shamt=01 -> bus_alu_m=0x02; shamt=10 -> 0x40; shamt=11 -> 0xC0.
REQ-027 IR control: with MDR=0xA8, apply ir_en=1 -> instruction=10101; then ir_sclr=1 and ir_en=1 together -> instruction=0.

Source files
------------

// File: rtl/memory_system.sv
// Datapath with an 8-entry register bank, ALU, shifter, flag register, and MAR/MDR/IR
// around a 2**DATA_WIDTH-word memory. There is no FSM; every load is driven directly by an input enable.
module memory_system #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ir_sclr,
    input  logic                  mar_sclr,
    input  logic                  enaf,
    input  logic [2:0]            selop,
    input  logic [1:0]            shamt,
    input  logic                  bank_wr_en,
    input  logic [2:0]            busB_addr,
    input  logic [2:0]            busC_addr,
    input  logic                  ir_en,
    input  logic                  mar_en,
    input  logic                  wr_rdn,
    input  logic                  mdr_alu_n,
    input  logic                  mdr_en,
    output logic [DATA_WIDTH-1:0] busC_m,
    output logic [DATA_WIDTH-1:0] bus_alu_m,
    output logic [DATA_WIDTH-1:0] PC_m,
    output logic [DATA_WIDTH-1:0] DPTR_m,
    output logic [DATA_WIDTH-1:0] A_m,
    output logic [DATA_WIDTH-1:0] TEMP_m,
    output logic [DATA_WIDTH-1:0] ACC_m,
    output logic [4:0]            instruction,
    output logic                  C,
    output logic                  N,
    output logic                  P,
    output logic                  Z
);
    localparam int W     = DATA_WIDTH;
    localparam int DEPTH = 1 << W;

    logic [W-1:0] bank [8];
    logic [W-1:0] mar;
    logic [W-1:0] mdr;
    logic [4:0]   ir_op;
    // Memory contents start at zero and are never touched by rst.
    logic [W-1:0] mem [DEPTH] = '{default: '0};

    logic [W-1:0] bus_b;
    logic [W-1:0] bus_c;
    logic [W-1:0] alu_x;
    logic [W-1:0] alu_out;
    logic [W-1:0] shift_out;
    logic         alu_carry;

    assign bus_b = bank[busB_addr];
    assign alu_x = bank[3'b111];

    always_comb begin
        alu_out   = '0;
        alu_carry = 1'b0;
        case (selop)
            3'b000: alu_out = bus_b;
            3'b001: {alu_carry, alu_out} = {1'b0, alu_x} + {1'b0, bus_b};
            3'b010: begin
                alu_out   = alu_x - bus_b;
                alu_carry = (alu_x < bus_b);
            end
            3'b011: alu_out = alu_x & bus_b;
            3'b100: alu_out = alu_x | bus_b;
            3'b101: alu_out = alu_x ^ bus_b;
            3'b110: {alu_carry, alu_out} = {1'b0, bus_b} + (W+1)'(1);
            3'b111: begin
                alu_out   = bus_b - W'(1);
                alu_carry = (bus_b == '0);
            end
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        shift_out = alu_out;
        case (shamt)
            2'b01:   shift_out = {alu_out[W-2:0], 1'b0};
            2'b10:   shift_out = {1'b0, alu_out[W-1:1]};
            2'b11:   shift_out = {alu_out[0], alu_out[W-1:1]};
            default: shift_out = alu_out;
        endcase
    end

    assign bus_c = mdr_alu_n ? mdr : shift_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) bank[i] <= '0;
        end else if (bank_wr_en) begin
            bank[busC_addr] <= bus_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            C <= 1'b0;
            N <= 1'b0;
            P <= 1'b0;
            Z <= 1'b0;
        end else if (enaf) begin
            C <= alu_carry;
            N <= shift_out[W-1];
            P <= ~^shift_out;
            Z <= (shift_out == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           mar <= '0;
        else if (mar_sclr) mar <= '0;
        else if (mar_en)   mar <= bus_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         mdr <= '0;
        else if (mdr_en) mdr <= wr_rdn ? shift_out : mem[mar];
    end

    // Memory write happens only when MDR is not loading, so MDR drives the old value in.
    always_ff @(posedge clk) begin
        if (!rst && !mdr_en && wr_rdn) mem[mar] <= mdr;
    end

    // Only the opcode field of IR is observable, so only those bits are stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          ir_op <= '0;
        else if (ir_sclr) ir_op <= '0;
        else if (ir_en)   ir_op <= mdr[W-1:W-5];
    end

    assign busC_m      = bus_c;
    assign bus_alu_m   = shift_out;
    assign PC_m        = bank[3'b000];
    assign DPTR_m      = bank[3'b001];
    assign A_m         = bank[3'b010];
    assign TEMP_m      = bank[3'b011];
    assign ACC_m       = bank[3'b111];
    assign instruction = ir_op;

endmodule

// File: tb/tb_memory_system.sv
// Directed bench for memory_system: reset, fetch, memory store/load, ALU flags,
// shifter modes, IR/MAR clear priority, simultaneous loads and asynchronous reset.
module tb_memory_system;
    logic       clk = 1'b0;
    logic       rst;
    logic       ir_sclr, mar_sclr, enaf, bank_wr_en, ir_en, mar_en, wr_rdn, mdr_alu_n, mdr_en;
    logic [2:0] selop, busB_addr, busC_addr;
    logic [1:0] shamt;
    logic [7:0] busC_m, bus_alu_m, PC_m, DPTR_m, A_m, TEMP_m, ACC_m;
    logic [4:0] instruction;
    logic       C, N, P, Z;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    memory_system #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .ir_sclr(ir_sclr), .mar_sclr(mar_sclr), .enaf(enaf),
        .selop(selop), .shamt(shamt), .bank_wr_en(bank_wr_en), .busB_addr(busB_addr),
        .busC_addr(busC_addr), .ir_en(ir_en), .mar_en(mar_en), .wr_rdn(wr_rdn),
        .mdr_alu_n(mdr_alu_n), .mdr_en(mdr_en), .busC_m(busC_m), .bus_alu_m(bus_alu_m),
        .PC_m(PC_m), .DPTR_m(DPTR_m), .A_m(A_m), .TEMP_m(TEMP_m), .ACC_m(ACC_m),
        .instruction(instruction), .C(C), .N(N), .P(P), .Z(Z)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_next(input string tag, input logic [7:0] obs);
        check(tag, obs, exp_q.pop_front());
    endtask

    task automatic set_idle();
        ir_sclr = 0; mar_sclr = 0; enaf = 0; bank_wr_en = 0; ir_en = 0; mar_en = 0;
        wr_rdn = 0; mdr_alu_n = 0; mdr_en = 0;
        selop = 3'b000; shamt = 2'b00; busB_addr = 3'b000; busC_addr = 3'b000;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        #20;
        rst = 1'b0;
    endtask

    task automatic op(input logic [2:0] sel, input logic [1:0] sh, input logic [2:0] bb,
                      input logic [2:0] bc, input logic wr, input logic fl);
        selop = sel; shamt = sh; busB_addr = bb; busC_addr = bc; bank_wr_en = wr; enaf = fl;
        tick();
        set_idle();
    endtask

    // Builds a constant in a bank register: shift left then optionally increment, MSB first.
    task automatic load_const(input logic [2:0] dst, input logic [7:0] val);
        for (int i = 7; i >= 0; i--) begin
            op(3'b000, 2'b01, dst, dst, 1'b1, 1'b0);
            if (val[i]) op(3'b110, 2'b00, dst, dst, 1'b1, 1'b0);
        end
    endtask

    task automatic set_mar(input logic [2:0] src);
        mar_en = 1; busB_addr = src;
        tick();
        set_idle();
    endtask

    task automatic mdr_from_reg(input logic [2:0] src);
        busB_addr = src; mdr_en = 1; wr_rdn = 1;
        tick();
        set_idle();
    endtask

    task automatic mdr_from_mem();
        mdr_en = 1; wr_rdn = 0;
        tick();
        set_idle();
    endtask

    task automatic mem_write();
        wr_rdn = 1;
        tick();
        set_idle();
    endtask

    task automatic fetch();
        set_mar(3'b000);
        selop = 3'b110; busB_addr = 3'b000; bank_wr_en = 1; busC_addr = 3'b000;
        mdr_en = 1; wr_rdn = 0;
        tick();
        set_idle();
    endtask

    task automatic check_mdr(input string tag, input logic [7:0] exp);
        mdr_alu_n = 1;
        #1;
        check(tag, busC_m, exp);
        mdr_alu_n = 0;
    endtask

    initial begin
        do_reset();

        // Reset values
        repeat (7) exp_q.push_back(8'h00);
        check_next("rst_pc", PC_m);
        check_next("rst_acc", ACC_m);
        check_next("rst_a", A_m);
        check_next("rst_dptr", DPTR_m);
        check_next("rst_temp", TEMP_m);
        check_next("rst_instr", 8'(instruction));
        check_next("rst_flags", 8'({C, N, P, Z}));

        // Fetch from power-up memory
        fetch();
        check("fetch_pc", PC_m, 8'h01);
        check_mdr("fetch_mdr_zero", 8'h00);

        // Store 0x5A at mem[0], fetch it and move it into ACC
        do_reset();
        load_const(3'b100, 8'h5A);
        set_mar(3'b000);
        mdr_from_reg(3'b100);
        mem_write();
        fetch();
        check("mov_pc", PC_m, 8'h01);
        mdr_alu_n = 1; bank_wr_en = 1; busC_addr = 3'b111;
        #1;
        check("mov_busc", busC_m, 8'h5A);
        tick();
        set_idle();
        check("mov_acc", ACC_m, 8'h5A);

        // Memory survives reset
        do_reset();
        fetch();
        check_mdr("mem_keep", 8'h5A);

        // Arithmetic and flags, flags packed as {C,N,P,Z}
        load_const(3'b111, 8'hFF);
        load_const(3'b010, 8'h01);
        selop = 3'b001; busB_addr = 3'b010; enaf = 1; bank_wr_en = 1; busC_addr = 3'b111;
        #1;
        check("add_alu", bus_alu_m, 8'h00);
        tick();
        set_idle();
        check("add_acc", ACC_m, 8'h00);
        exp_q.push_back(8'b1011);
        check_next("add_flags", 8'({C, N, P, Z}));

        op(3'b010, 2'b00, 3'b010, 3'b000, 1'b0, 1'b1);
        exp_q.push_back(8'b1110);
        check_next("sub_flags", 8'({C, N, P, Z}));
        op(3'b000, 2'b00, 3'b010, 3'b000, 1'b0, 1'b0);
        exp_q.push_back(8'b1110);
        check_next("hold_flags", 8'({C, N, P, Z}));
        op(3'b111, 2'b00, 3'b010, 3'b000, 1'b0, 1'b1);
        exp_q.push_back(8'b0011);
        check_next("dec1_flags", 8'({C, N, P, Z}));
        op(3'b111, 2'b00, 3'b011, 3'b000, 1'b0, 1'b1);
        exp_q.push_back(8'b1110);
        check_next("dec0_flags", 8'({C, N, P, Z}));
        op(3'b101, 2'b00, 3'b010, 3'b000, 1'b0, 1'b1);
        exp_q.push_back(8'b0000);
        check_next("xor_flags", 8'({C, N, P, Z}));

        // Shifter modes on ACC = 0x81
        load_const(3'b111, 8'h81);
        selop = 3'b000; busB_addr = 3'b111;
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h40);
        exp_q.push_back(8'hC0);
        for (int s = 0; s < 4; s++) begin
            shamt = 2'(s);
            #1;
            check_next("shift", bus_alu_m);
        end
        set_idle();

        // IR load and clear priority
        load_const(3'b101, 8'hA8);
        mdr_from_reg(3'b101);
        ir_en = 1;
        tick();
        set_idle();
        check("ir_load", 8'(instruction), 8'h15);
        ir_en = 1; ir_sclr = 1;
        tick();
        set_idle();
        check("ir_sclr", 8'(instruction), 8'h00);

        // MAR clear wins over load; then a real load to an unwritten address
        mar_en = 1; mar_sclr = 1; busB_addr = 3'b101;
        tick();
        set_idle();
        mdr_from_mem();
        check_mdr("mar_sclr", 8'h5A);
        set_mar(3'b101);
        mdr_from_mem();
        check_mdr("mar_load", 8'h00);

        // Simultaneous bank write, MAR load and MDR load use pre-edge operands
        mar_en = 1; busB_addr = 3'b000; selop = 3'b110; bank_wr_en = 1; busC_addr = 3'b000;
        mdr_en = 1; wr_rdn = 1;
        tick();
        set_idle();
        check("simul_pc", PC_m, 8'h02);
        check_mdr("simul_mdr", 8'h02);
        mem_write();
        mdr_from_reg(3'b011);
        check_mdr("simul_mdr_clr", 8'h00);
        mdr_from_mem();
        check_mdr("simul_mar", 8'h02);

        // Asynchronous reset mid-cycle, inputs ignored while held
        #1;
        rst = 1;
        #1;
        check("async_pc", PC_m, 8'h00);
        check("async_acc", ACC_m, 8'h00);
        selop = 3'b110; bank_wr_en = 1; busC_addr = 3'b000; busB_addr = 3'b000;
        tick();
        check("rst_hold_pc", PC_m, 8'h00);
        rst = 0;
        set_idle();
        op(3'b110, 2'b00, 3'b000, 3'b000, 1'b1, 1'b0);
        check("resume_pc", PC_m, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
